// File: rtl/pong_pkg.sv
// Field geometry and move encoding shared by the paddle, ball and video blocks.
package pong_pkg;
  localparam int POS_W       = 10;
  localparam int FIELD_Y_MIN = 0;
  localparam int FIELD_Y_MAX = 479;
  localparam int FIELD_X_MAX = 639;

  typedef enum logic [1:0] {HOLD, UP, DOWN} move_t;
endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle controls in, paddle position and limit flags out.
interface paddle_ctrl_if;
  import pong_pkg::*;

  logic             btn_up;
  logic             btn_down;
  logic             ai_en;
  logic [POS_W-1:0] ball_y_pos;
  logic [POS_W-1:0] paddle_pos;
  logic             at_top;
  logic             at_bottom;

  modport master (output btn_up, btn_down, ai_en, ball_y_pos,
                  input  paddle_pos, at_top, at_bottom);
  modport slave  (input  btn_up, btn_down, ai_en, ball_y_pos,
                  output paddle_pos, at_top, at_bottom);
endinterface

// File: rtl/paddle_ctrl_debounce.sv
// 2-FF synchroniser followed by a stability counter; output follows input
// only after DB_CYCLES consecutive cycles of disagreement.
module debounce #(
  parameter int DB_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_btn
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    r_sync;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_db   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (r_sync[1] != r_db) begin
        if (r_cnt == CW'(DB_CYCLES - 1)) begin
          r_db  <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_btn = r_db;
endmodule

// File: rtl/paddle_ctrl.sv
// One paddle: movement tick, manual/AI move decode and the clamped centre register.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int TICK_DIV  = 131072,
  parameter int DB_CYCLES = 65536,
  parameter int STEP      = 2,
  parameter int PAD_HALF  = 20,
  parameter int Y_MIN     = FIELD_Y_MIN,
  parameter int Y_MAX     = FIELD_Y_MAX,
  parameter int START_Y   = 240,
  parameter int DEADBAND  = 4
) (
  input logic          clk,
  input logic          reset_n,
  paddle_ctrl_if.slave bus
);
  localparam int          TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [10:0] LIM_TOP = 11'(Y_MIN + PAD_HALF);
  localparam logic [10:0] LIM_BOT = 11'(Y_MAX - PAD_HALF);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [10:0] DB11    = 11'(DEADBAND);
  localparam logic [10:0] START11 = 11'(START_Y);

  logic             w_up, w_down, w_tick;
  logic [1:0]       r_ai_sync;
  logic [TW-1:0]    r_tick_cnt;
  logic [POS_W-1:0] r_pos;
  logic             r_at_top, r_at_bottom;
  logic [10:0]      w_pos, w_ball, w_pos_nxt;
  move_t            w_move;

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .reset_n(reset_n), .i_btn(bus.btn_up), .o_btn(w_up));
  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk(clk), .reset_n(reset_n), .i_btn(bus.btn_down), .o_btn(w_down));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ai_sync  <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_ai_sync  <= {r_ai_sync[0], bus.ai_en};
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end
  end

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_pos  = {1'b0, r_pos};
  assign w_ball = {1'b0, bus.ball_y_pos};

  // In AI mode the buttons are ignored entirely.
  always_comb begin
    w_move = HOLD;
    if (r_ai_sync[1]) begin
      if (w_ball > w_pos + DB11)      w_move = DOWN;
      else if (w_ball + DB11 < w_pos) w_move = UP;
    end else if (w_up && !w_down) begin
      w_move = UP;
    end else if (w_down && !w_up) begin
      w_move = DOWN;
    end
  end

  always_comb begin
    w_pos_nxt = w_pos;
    if (w_tick) begin
      case (w_move)
        UP:      w_pos_nxt = (w_pos - STEP11 < LIM_TOP) ? LIM_TOP : w_pos - STEP11;
        DOWN:    w_pos_nxt = (w_pos + STEP11 > LIM_BOT) ? LIM_BOT : w_pos + STEP11;
        default: w_pos_nxt = w_pos;
      endcase
    end
  end

  // Flags come from the same next value so they stay coherent with r_pos.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos       <= START11[POS_W-1:0];
      r_at_top    <= (START11 == LIM_TOP);
      r_at_bottom <= (START11 == LIM_BOT);
    end else begin
      r_pos       <= w_pos_nxt[POS_W-1:0];
      r_at_top    <= (w_pos_nxt == LIM_TOP);
      r_at_bottom <= (w_pos_nxt == LIM_BOT);
    end
  end

  assign bus.paddle_pos = r_pos;
  assign bus.at_top     = r_at_top;
  assign bus.at_bottom  = r_at_bottom;
endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: scoreboard of expected position steps, timing checks and a decode table.
module tb_paddle_ctrl;
  localparam int TOP = 20, BOT = 459, START = 240;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  paddle_ctrl_if pif();

  paddle_ctrl #(.TICK_DIV(4), .DB_CYCLES(3), .STEP(2), .PAD_HALF(20),
                .START_Y(240), .DEADBAND(4))
    dut (.clk(clk), .reset_n(reset_n), .bus(pif.slave));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int ecnt = 0;
  int exp_q[$];
  bit mon_en = 1'b1;
  int last_pos = START;
  int bound_err = 0;

  typedef struct {
    logic up, down, ai;
    int   rel;
    int   delta;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset_n)
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;

  // Scoreboard: every position change must match the next queued value.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_pos = int'(pif.paddle_pos);
    end else begin
      if (pif.paddle_pos < TOP || pif.paddle_pos > BOT) bound_err++;
      if (int'(pif.paddle_pos) != last_pos) begin
        if (mon_en) begin
          if (exp_q.size() == 0) chk("sb_unexpected_move", int'(pif.paddle_pos), last_pos);
          else                   chk("sb_pos", int'(pif.paddle_pos), exp_q.pop_front());
          chk("sb_at_top", int'(pif.at_top), int'(pif.paddle_pos == TOP));
          chk("sb_at_bottom", int'(pif.at_bottom), int'(pif.paddle_pos == BOT));
        end
        last_pos = int'(pif.paddle_pos);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int t);
    while (ecnt < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pos(int tgt, int budget, string nm);
    int n = 0;
    while (int'(pif.paddle_pos) != tgt && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, int'(pif.paddle_pos), tgt);
  endtask

  function automatic int clampf(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  initial begin
    int p, e, p0, expv;
    pif.btn_up = 1'b0; pif.btn_down = 1'b0; pif.ai_en = 1'b0; pif.ball_y_pos = '0;
    tbl[0]  = '{1'b1, 1'b0, 1'b0,    0, -2};
    tbl[1]  = '{1'b0, 1'b1, 1'b0,    0,  2};
    tbl[2]  = '{1'b1, 1'b1, 1'b0,    0,  0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0,    0,  0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1,  100,  2};
    tbl[5]  = '{1'b1, 1'b0, 1'b1,  100,  2};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, -100, -2};
    tbl[7]  = '{1'b0, 1'b0, 1'b1,    4,  0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1,    5,  2};
    tbl[9]  = '{1'b0, 1'b0, 1'b1,   -4,  0};
    tbl[10] = '{1'b0, 1'b0, 1'b1,   -5, -2};
    tbl[11] = '{1'b1, 1'b0, 1'b0,    0, -2};

    // Reset state, then no movement before the first tick
    cyc(3);
    chk("rst_pos", int'(pif.paddle_pos), START);
    chk("rst_at_top", int'(pif.at_top), 0);
    chk("rst_at_bottom", int'(pif.at_bottom), 0);
    @(negedge clk) reset_n = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      wait_to(t);
      chk("post_rst_hold", int'(pif.paddle_pos), START);
    end

    // 2-cycle glitch is rejected
    cyc(1);
    pif.btn_up = 1'b1;
    cyc(2);
    pif.btn_up = 1'b0;
    cyc(20);
    chk("glitch_hold", int'(pif.paddle_pos), START);

    // Held button: first step timing, then clamp at the top
    p = ecnt;
    pif.btn_up = 1'b1;
    for (int v = START - 2; v >= TOP; v -= 2) exp_q.push_back(v);
    e = ((p + 6 + 3) / 4) * 4;
    wait_to(e - 1);
    chk("first_step_before", int'(pif.paddle_pos), START);
    wait_to(e);
    chk("first_step", int'(pif.paddle_pos), START - 2);
    wait_to(e + 4);
    chk("second_step", int'(pif.paddle_pos), START - 4);
    wait_pos(TOP, 600, "clamp_top_reached");
    cyc(20);
    chk("clamp_top_pos", int'(pif.paddle_pos), TOP);
    chk("clamp_top_flag", int'(pif.at_top), 1);
    chk("clamp_top_q", exp_q.size(), 0);

    // Down to the bottom limit; last step is clamped to an odd row
    pif.btn_up = 1'b0;
    pif.btn_down = 1'b1;
    for (int v = TOP + 2; v <= BOT; v += 2) exp_q.push_back(v);
    exp_q.push_back(BOT);
    wait_pos(BOT, 1200, "clamp_bot_reached");
    cyc(20);
    chk("clamp_bot_flag", int'(pif.at_bottom), 1);
    chk("clamp_bot_top_flag", int'(pif.at_top), 0);
    chk("clamp_bot_q", exp_q.size(), 0);
    chk("bounds", bound_err, 0);

    // Async reset while moving, then first move only after a full debounce + tick
    mon_en = 1'b0;
    pif.btn_down = 1'b0;
    pif.btn_up = 1'b1;
    wait_pos(BOT - 2, 40, "move_before_reset");
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_pos", int'(pif.paddle_pos), START);
    chk("async_rst_bot", int'(pif.at_bottom), 0);
    cyc(3);
    @(negedge clk) reset_n = 1'b1;
    wait_to(7);
    chk("rel_no_early_move", int'(pif.paddle_pos), START);
    wait_to(8);
    chk("rel_first_move", int'(pif.paddle_pos), START - 2);
    pif.btn_up = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cyc(1);
    chk("rst2_pos", int'(pif.paddle_pos), START);
    mon_en = 1'b1;

    // AI mode tracks the ball, opposing button ignored
    pif.ai_en = 1'b1;
    pif.ball_y_pos = 10'd300;
    pif.btn_up = 1'b1;
    for (int v = START + 2; v <= 296; v += 2) exp_q.push_back(v);
    wait_pos(296, 300, "ai_down_reached");
    cyc(40);
    chk("ai_down_hold", int'(pif.paddle_pos), 296);
    chk("ai_down_q", exp_q.size(), 0);
    pif.ball_y_pos = 10'd100;
    pif.btn_up = 1'b0;
    pif.btn_down = 1'b1;
    for (int v = 294; v >= 104; v -= 2) exp_q.push_back(v);
    wait_pos(104, 600, "ai_up_reached");
    cyc(40);
    chk("ai_up_hold", int'(pif.paddle_pos), 104);
    chk("ai_up_q", exp_q.size(), 0);

    // Both buttons in manual mode hold for 10 ticks
    pif.btn_up = 1'b1;
    cyc(10);
    pif.ai_en = 1'b0;
    cyc(8);
    for (int t = 0; t < 10; t++) begin
      cyc(4);
      chk("both_hold", int'(pif.paddle_pos), 104);
    end
    chk("both_hold_q", exp_q.size(), 0);

    // Decode table: one tick per row, ball placed relative to the current position
    mon_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pif.btn_up = tbl[i].up;
      pif.btn_down = tbl[i].down;
      pif.ai_en = tbl[i].ai;
      cyc(8);
      for (int k = 0; k < 4 && (ecnt % 4) != 0; k++) cyc(1);
      p0 = int'(pif.paddle_pos);
      pif.ball_y_pos = 10'(clampf(p0 + tbl[i].rel, 0, 1023));
      cyc(4);
      expv = clampf(p0 + tbl[i].delta, TOP, BOT);
      chk($sformatf("tbl_row%0d", i), int'(pif.paddle_pos), expv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
